// File: rtl/regfile_alu_engine_pkg.sv
// Shared encodings for the register-file / ALU / data-memory engine:
// command kinds, ALU op codes, FSM states and a constant log2 helper.
package regfile_alu_engine_pkg;

  typedef enum logic [1:0] {
    KIND_ALU_RR = 2'd0,
    KIND_ALU_RM = 2'd1,
    KIND_LOAD   = 2'd2,
    KIND_STORE  = 2'd3
  } cmd_kind_e;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_OR  = 3'd1,
    OP_XOR = 3'd2,
    OP_NOR = 3'd3,
    OP_ADD = 3'd4,
    OP_SUB = 3'd5,
    OP_SLT = 3'd6,
    OP_SLL = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  // Smallest n with 2**n >= value; usable in parameter expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_alu_engine_alu_core.sv
// Combinational ALU: logic ops, add/sub with signed overflow, slt and sll.
module alu_core
  import regfile_alu_engine_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_e           op,
  output logic [DATA_W-1:0] F,
  output logic              OF,
  output logic              ZF
);

  localparam int SHW = clog2(DATA_W);

  logic [DATA_W-1:0] sum_s;
  logic [DATA_W-1:0] diff_s;

  assign sum_s  = a + b;
  assign diff_s = a - b;

  // Operation select; only add/sub can raise overflow.
  always_comb begin
    F  = {DATA_W{1'b0}};
    OF = 1'b0;
    case (op)
      OP_AND: F = a & b;
      OP_OR:  F = a | b;
      OP_XOR: F = a ^ b;
      OP_NOR: F = ~(a | b);
      OP_ADD: begin
        F  = sum_s;
        OF = (a[DATA_W-1] == b[DATA_W-1]) && (sum_s[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        F  = diff_s;
        OF = (a[DATA_W-1] != b[DATA_W-1]) && (diff_s[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SLT: F = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL: F = b << a[SHW-1:0];
      default: begin
        F  = {DATA_W{1'b0}};
        OF = 1'b0;
      end
    endcase
  end

  assign ZF = (F == {DATA_W{1'b0}});

endmodule

// File: rtl/regfile_alu_engine.sv
// Sequenced execution engine: one command at a time through IDLE/MEM/EXEC/WB,
// with an inferred register file (r0 hardwired to zero) and local data memory.
module regfile_alu_engine
  import regfile_alu_engine_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int REG_N  = 32,
  parameter  int MEM_AW = 6,
  localparam int RA_W   = clog2(REG_N)
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_kind,
  input  logic [2:0]        cmd_op,
  input  logic [RA_W-1:0]   cmd_rd,
  input  logic [RA_W-1:0]   cmd_ra,
  input  logic [RA_W-1:0]   cmd_rb,
  input  logic [MEM_AW-1:0] cmd_maddr,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              OF,
  output logic              ZF,
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int MEM_D = 2 ** MEM_AW;

  state_e            state_r;
  cmd_kind_e         kind_r;
  alu_op_e           op_r;
  logic [RA_W-1:0]   rd_r;
  logic [RA_W-1:0]   ra_r;
  logic [RA_W-1:0]   rb_r;
  logic [MEM_AW-1:0] maddr_r;
  logic [DATA_W-1:0] mem_data_r;
  logic [DATA_W-1:0] regs_r [REG_N];
  logic [DATA_W-1:0] mem_r  [MEM_D];

  logic              accept_s;
  logic              reg_we_s;
  logic              mem_we_s;
  logic [DATA_W-1:0] opa_s;
  logic [DATA_W-1:0] opb_s;
  logic [DATA_W-1:0] alu_f_s;
  logic              alu_of_s;
  logic              alu_zf_s;
  cmd_kind_e         cmd_kind_s;

  assign cmd_kind_s = cmd_kind_e'(cmd_kind);
  assign cmd_ready  = (state_r == ST_IDLE) && !Reset;
  assign accept_s   = cmd_valid && cmd_ready;

  assign opa_s    = (ra_r == {RA_W{1'b0}}) ? {DATA_W{1'b0}} : regs_r[ra_r];
  assign dbg_data = (dbg_addr == {RA_W{1'b0}}) ? {DATA_W{1'b0}} : regs_r[dbg_addr];

  // Operand B comes from the memory capture for reg-mem ops, else from R[rb].
  always_comb begin
    opb_s = {DATA_W{1'b0}};
    if (kind_r == KIND_ALU_RM) begin
      opb_s = mem_data_r;
    end else if (rb_r != {RA_W{1'b0}}) begin
      opb_s = regs_r[rb_r];
    end else begin
      opb_s = {DATA_W{1'b0}};
    end
  end

  assign reg_we_s = (state_r == ST_WB) && (kind_r != KIND_STORE) &&
                    (rd_r != {RA_W{1'b0}}) && !Reset;
  assign mem_we_s = (state_r == ST_WB) && (kind_r == KIND_STORE) && !Reset;

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .a  (opa_s),
    .b  (opb_s),
    .op (op_r),
    .F  (alu_f_s),
    .OF (alu_of_s),
    .ZF (alu_zf_s)
  );

  // Command sequencer with registered result, flags and done pulse.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_r <= ST_IDLE;
      kind_r  <= KIND_ALU_RR;
      op_r    <= OP_AND;
      rd_r    <= {RA_W{1'b0}};
      ra_r    <= {RA_W{1'b0}};
      rb_r    <= {RA_W{1'b0}};
      maddr_r <= {MEM_AW{1'b0}};
      result  <= {DATA_W{1'b0}};
      OF      <= 1'b0;
      ZF      <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            kind_r  <= cmd_kind_s;
            op_r    <= alu_op_e'(cmd_op);
            rd_r    <= cmd_rd;
            ra_r    <= cmd_ra;
            rb_r    <= cmd_rb;
            maddr_r <= cmd_maddr;
            if ((cmd_kind_s == KIND_ALU_RM) || (cmd_kind_s == KIND_LOAD)) begin
              state_r <= ST_MEM;
            end else begin
              state_r <= ST_EXEC;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_MEM: state_r <= ST_EXEC;
        ST_EXEC: begin
          case (kind_r)
            KIND_ALU_RR, KIND_ALU_RM: begin
              result <= alu_f_s;
              OF     <= alu_of_s;
              ZF     <= alu_zf_s;
            end
            KIND_LOAD:  result <= mem_data_r;
            KIND_STORE: result <= opa_s;
            default:    result <= result;
          endcase
          done    <= 1'b1;
          state_r <= ST_WB;
        end
        ST_WB:   state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Register file: cleared on reset, single write port used in WB.
  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int i = 0; i < REG_N; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (reg_we_s) begin
      regs_r[rd_r] <= result;
    end
  end

  // Data memory: contents survive reset; read captured during MEM.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[maddr_r] <= opa_s;
    end
    if (state_r == ST_MEM) begin
      mem_data_r <= mem_r[maddr_r];
    end
  end

endmodule

// File: tb/tb_regfile_alu_engine.sv
// Self-checking bench: directed cases with literal expectations, then random
// commands, all compared every cycle against a behavioural model.
module tb_regfile_alu_engine;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_kind = 2'd0;
  logic [2:0]  cmd_op = 3'd0;
  logic [4:0]  cmd_rd = 5'd0, cmd_ra = 5'd0, cmd_rb = 5'd0, dbg_addr = 5'd0;
  logic [5:0]  cmd_maddr = 6'd0;
  logic        done, OF, ZF;
  logic [31:0] result, dbg_data;

  int n_vec = 0;
  int n_bad = 0;

  // behavioural model state
  logic [31:0] m_regs [32];
  logic [31:0] m_mem  [64];
  logic [31:0] m_result, p_val;
  logic        m_of, m_zf, m_done, p_of;
  int          m_cnt, p_kind;
  logic [4:0]  p_rd;
  logic [5:0]  p_maddr;

  always #5 clk = ~clk;

  regfile_alu_engine #(.DATA_W(32), .REG_N(32), .MEM_AW(6)) dut (
    .clk(clk), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_kind(cmd_kind), .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra),
    .cmd_rb(cmd_rb), .cmd_maddr(cmd_maddr), .done(done), .result(result),
    .OF(OF), .ZF(ZF), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input int op, input logic [31:0] a,
                                          input logic [31:0] b, output logic of);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    of = 1'b0;
    case (op)
      0: return a & b;
      1: return a | b;
      2: return a ^ b;
      3: return ~(a | b);
      4: begin s = sa + sb; of = (s > 64'sd2147483647) || (s < -64'sd2147483648); return a + b; end
      5: begin s = sa - sb; of = (s > 64'sd2147483647) || (s < -64'sd2147483648); return a - b; end
      6: return (sa < sb) ? 32'd1 : 32'd0;
      7: return b << (a % 32);
      default: return 32'd0;
    endcase
  endfunction

  // Model: a command takes 2 or 3 cycles to done, effects land one edge later.
  initial begin
    m_cnt = 0; m_done = 1'b0; m_result = 32'd0; m_of = 1'b0; m_zf = 1'b0;
    foreach (m_regs[i]) m_regs[i] = 32'd0;
    foreach (m_mem[i]) m_mem[i] = 32'd0;
    forever begin
      @(posedge clk);
      if (Reset) begin
        m_cnt = 0; m_done = 1'b0; m_result = 32'd0; m_of = 1'b0; m_zf = 1'b0;
        foreach (m_regs[i]) m_regs[i] = 32'd0;
      end else if (m_cnt == 0) begin
        if (cmd_valid) begin
          p_kind = int'(cmd_kind); p_rd = cmd_rd; p_maddr = cmd_maddr; p_of = 1'b0;
          case (p_kind)
            0: p_val = alu_ref(int'(cmd_op), m_regs[cmd_ra], m_regs[cmd_rb], p_of);
            1: p_val = alu_ref(int'(cmd_op), m_regs[cmd_ra], m_mem[cmd_maddr], p_of);
            2: p_val = m_mem[cmd_maddr];
            default: p_val = m_regs[cmd_ra];
          endcase
          m_cnt = (p_kind == 1 || p_kind == 2) ? 3 : 2;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 1) begin
          m_done = 1'b1;
          m_result = p_val;
          if (p_kind < 2) begin m_of = p_of; m_zf = (p_val == 32'd0); end
        end else if (m_cnt == 0) begin
          m_done = 1'b0;
          if (p_kind == 3) m_mem[p_maddr] = p_val;
          else if (p_rd != 5'd0) m_regs[p_rd] = p_val;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("cmd_ready", 32'(cmd_ready), 32'((m_cnt == 0) && !Reset));
      check("done", 32'(done), 32'(m_done));
      check("result", result, m_result);
      check("OF", 32'(OF), 32'(m_of));
      check("ZF", 32'(ZF), 32'(m_zf));
      check("dbg_data", dbg_data, m_regs[dbg_addr]);
    end
  end

  task automatic issue(input logic [1:0] k, input logic [2:0] op, input logic [4:0] rd,
                       input logic [4:0] ra, input logic [4:0] rb, input logic [5:0] ma,
                       input bit hold, output int lat);
    int guard;
    guard = 0;
    @(posedge clk); #2;
    while (!cmd_ready && guard < 50) begin @(posedge clk); #2; guard++; end
    if (!cmd_ready) check("ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_kind = k; cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_maddr = ma;
    dbg_addr = 5'($urandom_range(0, 31));
    cmd_valid = 1'b1;
    @(posedge clk); #2;
    if (!hold) cmd_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic chk_reg(input logic [4:0] addr, input logic [31:0] exp, input string name);
    @(posedge clk); #2;
    dbg_addr = addr;
    #1 check(name, dbg_data, exp);
  endtask

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #2 Reset = 1'b0;
    #1;
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_result", result, 32'd0);
    check("rst_OF", 32'(OF), 32'd0);
    check("rst_ZF", 32'(ZF), 32'd0);
    for (int i = 0; i < 32; i++) chk_reg(5'(i), 32'd0, "rst_reg");
    for (int a = 0; a < 64; a++) issue(2'd3, 3'd0, 5'd0, 5'd0, 5'd0, 6'(a), 1'b0, lat);

    issue(2'd0, 3'd3, 5'd5, 5'd0, 5'd0, 6'd0, 1'b0, lat);   // r5 = nor(0,0)
    check("nor", result, 32'hFFFF_FFFF);
    issue(2'd0, 3'd6, 5'd2, 5'd5, 5'd0, 6'd0, 1'b0, lat);   // r2 = slt(-1,0)
    check("slt_m1_0", result, 32'd1);
    issue(2'd0, 3'd7, 5'd6, 5'd5, 5'd5, 6'd0, 1'b0, lat);   // r6 = -1 << 31
    check("sll31", result, 32'h8000_0000);
    issue(2'd0, 3'd5, 5'd1, 5'd6, 5'd2, 6'd0, 1'b0, lat);   // r1 = r6 - 1
    check("sub_of_res", result, 32'h7FFF_FFFF);
    check("sub_of_OF", 32'(OF), 32'd1);
    check("lat_rr", 32'(lat), 32'd2);

    issue(2'd3, 3'd0, 5'd0, 5'd1, 5'd0, 6'd5, 1'b0, lat);   // mem[5] = r1
    check("lat_store", 32'(lat), 32'd2);
    check("store_result", result, 32'h7FFF_FFFF);
    issue(2'd2, 3'd0, 5'd3, 5'd0, 5'd0, 6'd5, 1'b0, lat);   // r3 = mem[5]
    check("lat_load", 32'(lat), 32'd3);
    chk_reg(5'd3, 32'h7FFF_FFFF, "load_r3");

    issue(2'd0, 3'd4, 5'd7, 5'd1, 5'd2, 6'd0, 1'b0, lat);
    check("add_res", result, 32'h8000_0000);
    check("add_OF", 32'(OF), 32'd1);
    check("add_ZF", 32'(ZF), 32'd0);
    issue(2'd0, 3'd5, 5'd8, 5'd2, 5'd2, 6'd0, 1'b0, lat);
    check("sub0_res", result, 32'd0);
    check("sub0_ZF", 32'(ZF), 32'd1);
    check("sub0_OF", 32'(OF), 32'd0);
    issue(2'd0, 3'd1, 5'd4, 5'd5, 5'd0, 6'd0, 1'b0, lat);   // r4 = -1
    issue(2'd0, 3'd6, 5'd9, 5'd4, 5'd2, 6'd0, 1'b0, lat);
    check("slt_m1_1", result, 32'd1);

    issue(2'd0, 3'd4, 5'd10, 5'd2, 5'd2, 6'd0, 1'b0, lat);  // build 0x21 in r11
    issue(2'd0, 3'd4, 5'd10, 5'd10, 5'd10, 6'd0, 1'b0, lat);
    issue(2'd0, 3'd4, 5'd10, 5'd10, 5'd2, 6'd0, 1'b0, lat);
    issue(2'd0, 3'd7, 5'd11, 5'd10, 5'd2, 6'd0, 1'b0, lat);
    issue(2'd0, 3'd4, 5'd11, 5'd11, 5'd2, 6'd0, 1'b0, lat);
    chk_reg(5'd11, 32'h21, "r11_0x21");
    issue(2'd0, 3'd7, 5'd12, 5'd11, 5'd2, 6'd0, 1'b0, lat);
    check("sll_mod", result, 32'd2);

    issue(2'd0, 3'd4, 5'd0, 5'd1, 5'd2, 6'd0, 1'b0, lat);   // rd = 0
    check("rd0_done", 32'(done), 32'd1);
    chk_reg(5'd0, 32'd0, "r0_zero");
    issue(2'd0, 3'd4, 5'd13, 5'd13, 5'd2, 6'd0, 1'b1, lat); // valid held while busy
    chk_reg(5'd13, 32'd1, "hold_once");
    issue(2'd1, 3'd2, 5'd15, 5'd1, 5'd0, 6'd5, 1'b0, lat);  // r1 ^ mem[5]
    check("lat_rm", 32'(lat), 32'd3);
    check("rm_ZF", 32'(ZF), 32'd1);

    // reset while a LOAD is in MEM
    @(posedge clk); #2;
    cmd_kind = 2'd2; cmd_rd = 5'd14; cmd_maddr = 6'd5; cmd_valid = 1'b1;
    @(posedge clk); #2;
    cmd_valid = 1'b0; Reset = 1'b1;
    @(posedge clk); #2;
    Reset = 1'b0;
    #1 check("ready_after_reset", 32'(cmd_ready), 32'd1);
    repeat (4) @(posedge clk);
    chk_reg(5'd14, 32'd0, "reset_no_write");

    for (int n = 0; n < 400; n++) begin
      issue(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)),
            ($urandom_range(0, 3) == 0), lat);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
